wb_prog_loader: RTL

Synthesizable Wishbone B3 master that copies a program image, delivered as a valid/ready stream of 32-bit words, into system memory before the CPU runs. It is the hardware counterpart of the simulation backdoor ELF load: it sits between an image source (JTAG/SPI fetch engine or bench driver) and the SoC memory arbiter. It holds the CPU in reset until the whole image is written. Words are written sequentially from BASE_ADDR, one single-beat classic write per word.

---
 rtl/wb_prog_loader.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/wb_prog_loader.sv
// wb_prog_loader
//
// Wishbone B3 master that copies a program image, delivered as a valid/ready
// stream of 32-bit words, into system memory before the CPU is released.
// Every word becomes one single-beat classic write, placed sequentially from
// BASE_ADDR. The CPU is held in reset until the last-flagged word is acked.
// A bus error, an ack timeout, or running past MAX_WORDS aborts the load and
// keeps the CPU in reset.
//
// Ports:
//   wb_clk_i      system clock
//   wb_rst_i      synchronous active-high reset
//   ld_valid_i    stream word valid
//   ld_ready_o    loader accepts a word (idle and not in reset)
//   ld_data_i     image word, memory byte order (byte 0 in [31:24])
//   ld_last_i     final word of the image, qualified by ld_valid_i
//   wbm_adr_o     byte address of the current write
//   wbm_dat_o     write data
//   wbm_sel_o     byte selects (all lanes during a write)
//   wbm_we_o      write enable
//   wbm_cyc_o     bus cycle
//   wbm_stb_o     strobe
//   wbm_cti_o     cycle type (classic)
//   wbm_bte_o     burst type (linear)
//   wbm_ack_i     slave ack
//   wbm_err_i     slave error
//   cpu_rst_o     CPU reset, high until the load completes
//   done_o        image fully written
//   error_o       load aborted
//   word_count_o  number of words successfully written
module wb_prog_loader #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter logic [31:0] MAX_WORDS   = 32'h0080_0000,
    parameter int unsigned ACK_TIMEOUT = 256
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        ld_valid_i,
    output logic        ld_ready_o,
    input  logic [31:0] ld_data_i,
    input  logic        ld_last_i,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    output logic [3:0]  wbm_sel_o,
    output logic        wbm_we_o,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic [2:0]  wbm_cti_o,
    output logic [1:0]  wbm_bte_o,
    input  logic        wbm_ack_i,
    input  logic        wbm_err_i,
    output logic        cpu_rst_o,
    output logic        done_o,
    output logic        error_o,
    output logic [31:0] word_count_o
);

    // Last WRITE cycle on which an ack or err is still accepted.
    localparam logic [31:0] TIMEOUT_LAST = 32'(ACK_TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, WRITE, DONE, ERROR} state_e;

    state_e      state_q, state_d;
    logic [31:0] adr_q, adr_d;
    logic [31:0] dat_q, dat_d;
    logic [31:0] wordCount_q, wordCount_d;
    logic [31:0] timeout_q, timeout_d;
    logic        lastSeen_q, lastSeen_d;
    logic        busCycle_q, busCycle_d;
    logic        cpuRst_q, cpuRst_d;
    logic        done_q, done_d;
    logic        error_q, error_d;

    logic        accept;
    logic        ackOk;

    // Ready is the only combinational output so a word can be taken the
    // cycle the loader returns to IDLE; reset forces it low immediately.
    assign ld_ready_o = (state_q == IDLE) & ~wb_rst_i;
    assign accept     = ld_valid_i & ld_ready_o;
    assign ackOk      = wbm_ack_i & ~wbm_err_i;

    // State register.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. An error response wins over a simultaneous ack, and
    // a last-flagged word completes the load even if it fills memory exactly.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = WRITE;
                end
            end
            WRITE: begin
                if (wbm_err_i) begin
                    state_d = ERROR;
                end else if (wbm_ack_i) begin
                    if (lastSeen_q) begin
                        state_d = DONE;
                    end else if (wordCount_q + 32'd1 == MAX_WORDS) begin
                        state_d = ERROR;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (timeout_q == TIMEOUT_LAST) begin
                    state_d = ERROR;
                end
            end
            default: begin
                state_d = state_q;
            end
        endcase
    end

    // Output/datapath next values. Bus and status flags are computed from the
    // next state so that they appear registered in the same cycle the FSM
    // enters the corresponding state.
    always_comb begin
        adr_d       = adr_q;
        dat_d       = dat_q;
        wordCount_d = wordCount_q;
        timeout_d   = timeout_q;
        lastSeen_d  = lastSeen_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    adr_d      = BASE_ADDR + {wordCount_q[29:0], 2'b00};
                    dat_d      = ld_data_i;
                    lastSeen_d = ld_last_i;
                    timeout_d  = '0;
                end
            end
            WRITE: begin
                if (ackOk) begin
                    wordCount_d = wordCount_q + 32'd1;
                end else if (!wbm_err_i) begin
                    timeout_d = timeout_q + 32'd1;
                end
            end
            default: begin
                adr_d = adr_q;
            end
        endcase
        busCycle_d = (state_d == WRITE);
        cpuRst_d   = (state_d != DONE);
        done_d     = (state_d == DONE);
        error_d    = (state_d == ERROR);
    end

    // Datapath and output registers.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            adr_q       <= '0;
            dat_q       <= '0;
            wordCount_q <= '0;
            timeout_q   <= '0;
            lastSeen_q  <= 1'b0;
            busCycle_q  <= 1'b0;
            cpuRst_q    <= 1'b1;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            adr_q       <= adr_d;
            dat_q       <= dat_d;
            wordCount_q <= wordCount_d;
            timeout_q   <= timeout_d;
            lastSeen_q  <= lastSeen_d;
            busCycle_q  <= busCycle_d;
            cpuRst_q    <= cpuRst_d;
            done_q      <= done_d;
            error_q     <= error_d;
        end
    end

    assign wbm_adr_o    = adr_q;
    assign wbm_dat_o    = dat_q;
    assign wbm_sel_o    = busCycle_q ? 4'hF : 4'h0;
    assign wbm_we_o     = busCycle_q;
    assign wbm_cyc_o    = busCycle_q;
    assign wbm_stb_o    = busCycle_q;
    assign wbm_cti_o    = 3'b000;
    assign wbm_bte_o    = 2'b00;
    assign cpu_rst_o    = cpuRst_q;
    assign done_o       = done_q;
    assign error_o      = error_q;
    assign word_count_o = wordCount_q;

endmodule
